// File: rtl/axi_pkg.sv
// Shared constants, FSM encoding and helpers for the AXI read master.
package axi_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [3:0] AXCACHE_DEF = 4'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_NEXT,
    S_DONE
  } rd_state_t;

  // ceil(log2(n)); 0 for n <= 1
  function automatic int clogb2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered output stage; an empty FIFO forwards a
// write straight into the output register so it is visible the next cycle.
module sync_fifo
  import axi_pkg::*;
#(
  parameter int WIDTH = 65,
  parameter int DEPTH = 32,
  parameter int AW    = clogb2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      mem_cnt;
  logic             load, mem_empty, bypass, mem_wr, mem_rd;

  always_comb begin
    mem_empty = (mem_cnt == '0);
    load      = !rd_valid || rd_en;
    bypass    = load && mem_empty && wr_en;
    mem_wr    = wr_en && !bypass;
    mem_rd    = load && !mem_empty;
  end

  // the output register counts as one entry of capacity
  assign count = mem_cnt + {{AW{1'b0}}, rd_valid};
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      mem_cnt  <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (mem_wr) wptr <= wptr + AW'(1);
      if (mem_rd) rptr <= rptr + AW'(1);
      case ({mem_wr, mem_rd})
        2'b10:   mem_cnt <= mem_cnt + (AW+1)'(1);
        2'b01:   mem_cnt <= mem_cnt - (AW+1)'(1);
        default: ;
      endcase
      if (load) begin
        rd_valid <= bypass || mem_rd;
        if (mem_rd)      rd_data <= mem[rptr];
        else if (bypass) rd_data <= wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_wr) mem[wptr] <= wr_data;
  end

endmodule

// File: rtl/axi_read.sv
// AXI4 read master: issues burst_num INCR bursts and streams the returned
// beats out as AXI-stream, tlast marking the end of each burst.
module axi_read
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int AR_LEN     = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                  m_axi_aclk,
  input  logic                  m_axi_areset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [15:0]           burst_num,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_err,
  output logic [DATA_WIDTH-1:0] M_RD_tdata,
  output logic                  M_RD_tvalid,
  output logic                  M_RD_tlast,
  input  logic                  M_RD_tready,
  output logic                  m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic [3:0]            m_axi_arqos,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic                  m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam int CW = clogb2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(AR_LEN * DATA_WIDTH / 8);
  localparam logic [7:0]    LAST_BEAT = 8'(AR_LEN - 1);
  localparam logic [CW-1:0] CRED_LEN  = CW'(AR_LEN);
  localparam logic [CW-1:0] CRED_MAX  = CW'(FIFO_DEPTH - AR_LEN);

  rd_state_t               state, state_n;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [15:0]             remaining;
  logic [7:0]              beat_cnt;
  logic [CW-1:0]           credits;
  logic                    ar_hs, r_hs, last_beat, space_ok, pop, r_bad;
  logic                    fifo_full, fifo_empty;
  logic [DATA_WIDTH:0]     fifo_rd;
  logic [CW-1:0]           unused_fifo_count;
  logic                    unused_rid;

  assign m_axi_arid    = 1'b0;
  assign m_axi_arlen   = LAST_BEAT;
  assign m_axi_arsize  = 3'(clogb2(DATA_WIDTH / 8));
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = AXCACHE_DEF;
  assign m_axi_arprot  = 3'd0;
  assign m_axi_arqos   = 4'd0;
  assign unused_rid    = m_axi_rid;

  assign ar_hs     = m_axi_arvalid && m_axi_arready;
  assign r_hs      = m_axi_rvalid && m_axi_rready;
  assign last_beat = (beat_cnt == LAST_BEAT);
  assign pop       = M_RD_tvalid && M_RD_tready;
  assign r_bad     = (m_axi_rresp != RESP_OKAY) || (m_axi_rlast != last_beat);
  // credits cover in-flight plus resident beats, so they alone bound the FIFO
  assign space_ok  = (credits <= CRED_MAX);

  assign M_RD_tdata = fifo_rd[DATA_WIDTH:1];
  assign M_RD_tlast = fifo_rd[0];

  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) state <= S_IDLE;
    else              state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (start) state_n = (burst_num == 16'd0) ? S_DONE : S_ADDR;
      S_ADDR: if (ar_hs) state_n = S_DATA;
      S_DATA: if (r_hs && last_beat) state_n = S_NEXT;
      S_NEXT: state_n = (remaining == 16'd1) ? S_DONE : S_ADDR;
      S_DONE: if (fifo_empty) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    m_axi_rready = (state == S_DATA) && !fifo_full;
  end

  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) begin
      addr          <= '0;
      remaining     <= '0;
      beat_cnt      <= '0;
      credits       <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      rd_err        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          addr      <= base_addr;
          remaining <= burst_num;
          rd_err    <= 1'b0;
          busy      <= (burst_num != 16'd0);
        end
        S_ADDR: begin
          if (!m_axi_arvalid && space_ok) begin
            m_axi_arvalid <= 1'b1;
            m_axi_araddr  <= addr;
          end else if (ar_hs) begin
            m_axi_arvalid <= 1'b0;
          end
          beat_cnt <= '0;
        end
        S_DATA: if (r_hs) begin
          beat_cnt <= last_beat ? 8'd0 : beat_cnt + 8'd1;
          if (r_bad) rd_err <= 1'b1;
        end
        S_NEXT: begin
          remaining <= remaining - 16'd1;
          addr      <= addr + BURST_BYTES;
        end
        S_DONE: if (fifo_empty) begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase

      case ({ar_hs, pop})
        2'b10:   credits <= credits + CRED_LEN;
        2'b01:   credits <= credits - CW'(1);
        2'b11:   credits <= credits + CRED_LEN - CW'(1);
        default: ;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (m_axi_aclk),
    .rst      (m_axi_areset),
    .wr_en    (r_hs),
    .wr_data  ({m_axi_rdata, last_beat}),
    .rd_en    (pop),
    .rd_data  (fifo_rd),
    .rd_valid (M_RD_tvalid),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (unused_fifo_count)
  );

endmodule

// File: doc/axi_read.md
Name: axi_read

Overview:
- AXI4 read master; read-side counterpart of the stream-to-AXI write block.
- On a start pulse, issues `burst_num` INCR bursts of AR_LEN beats from `base_addr`. Returned data is converted into an AXI-stream output, with tlast on the last beat of each burst.
- A credit-checked internal FIFO absorbs stream back-pressure, so the AXI R channel never stalls mid-burst while space is reserved.
- Sits between the DDR/interconnect port and downstream stream consumers.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 64, AXI/stream data width; power of 2, 8..1024.
- AR_LEN, 16, beats per burst (1-256). AR_LEN*DATA_WIDTH/8 must be ≤ 4096.
- FIFO_DEPTH, 32, internal FIFO entries; power of 2, ≥ AR_LEN.

Ports:
- m_axi_aclk  in  1  sole clock.
- m_axi_areset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; sampled only while busy=0.
- base_addr  in  ADDR_WIDTH  first burst address. Must be aligned to AR_LEN*DATA_WIDTH/8.
- burst_num  in  16  number of bursts.
- busy  out  1  high from the start acceptance until done.
- done  out  1  one-cycle pulse when the job completes.
- rd_err  out  1  sticky; set on any rresp≠OKAY; cleared on start.
- M_RD_tdata  out  DATA_WIDTH  stream data.
- M_RD_tvalid  out  1  stream valid.
- M_RD_tlast  out  1  last beat of each burst.
- M_RD_tready  in  1  stream ready.
- m_axi_arid  out  1  constant 0.
- m_axi_araddr  out  ADDR_WIDTH  burst address.
- m_axi_arlen  out  8  AR_LEN-1.
- m_axi_arsize  out  3  clog2(DATA_WIDTH/8).
- m_axi_arburst  out  2  constant 2'b01 (INCR).
- m_axi_arlock  out  1  constant 0.
- m_axi_arcache  out  4  constant 4'd3.
- m_axi_arprot  out  3  constant 0.
- m_axi_arqos  out  4  constant 0.
- m_axi_arvalid  out  1  AR valid.
- m_axi_arready  in  1  AR ready.
- m_axi_rid  in  1  ignored.
- m_axi_rdata  in  DATA_WIDTH  read data.
- m_axi_rresp  in  2  read response.
- m_axi_rlast  in  1  last beat from the slave.
- m_axi_rvalid  in  1  R valid.
- m_axi_rready  out  1  R ready.

Behaviour:
- Reset (async, active-high) forces all of the following to 0: arvalid, araddr, rready, busy, done, rd_err, M_RD_tvalid, M_RD_tlast, M_RD_tdata. It also clears the FSM (to IDLE), counters, FIFO and credits.
  - A reset mid-burst abandons the transaction silently.
  - No AR is issued until a new start.
- FSM states: IDLE, ADDR, DATA, NEXT, DONE.
  - IDLE: on start, latch base_addr and burst_num, and clear rd_err.
    - If burst_num=0, go to DONE (no AXI traffic).
    - Otherwise set busy=1 and go to ADDR.
  - ADDR: assert arvalid only when free FIFO entries minus reserved credits ≥ AR_LEN.
    - arvalid/araddr are registered and held stable until arready.
    - On handshake: reserve AR_LEN credits and go to DATA.
  - DATA: rready=1 (space is guaranteed; gated with FIFO not-full as a safety).
    - Each R handshake writes {rdata, beat_cnt==AR_LEN-1} to the FIFO.
    - Leave on the handshake of beat AR_LEN-1. tlast is derived from the beat counter, not from rlast.
  - NEXT: decrement remaining bursts and add AR_LEN*DATA_WIDTH/8 to the address (wraps modulo 2^ADDR_WIDTH).
    - Go to DONE if remaining=0, else ADDR.
  - DONE: wait until the FIFO is empty, then pulse done for 1 cycle, drop busy, and return to IDLE.
- One outstanding burst at a time.
- Credits are released as beats pop from the FIFO. A pop and a reservation in the same cycle net correctly.
- rd_err sets on any R handshake with rresp≠2'b00. The data is still forwarded.
- A mismatch between rlast and the beat counter also sets rd_err.
- Stream output follows standard AXIS rules: tdata/tlast are stable while tvalid && !tready.
- Latency: an R beat is visible on M_RD_tvalid 1 cycle after the handshake when the FIFO is empty. Full throughput is 1 beat/cycle.
- FIFO simultaneous push and pop while full is not possible, because of credits. While empty, push-then-pop occurs on the next cycle.
- start while busy is ignored.

Decomposition:
- Shared package axi_pkg:
  - BURST_INCR=2'b01, RESP_OKAY=2'b00, AXCACHE_DEF=4'd3.
  - FSM state encoding.
  - The clogb2 function.
- Sub-module sync_fifo (DATA_WIDTH+1 wide, FIFO_DEPTH deep): registered output, with full/empty/count outputs.

Test Plan:
- Single burst: AR_LEN=16, DATA_WIDTH=64, base=0x1000, burst_num=1, tready=1 → one AR with araddr=0x1000, arlen=15, arsize=3. Stream carries 16 beats in order, tlast on beat 16, then done pulses and busy falls.
- Multi-burst: base=0, burst_num=3 → araddr sequence 0x000, 0x080, 0x100. Three tlast pulses; data matches memory model.
- Back-pressure: FIFO_DEPTH=32, tready=0 → two bursts accepted, third arvalid withheld. After 16 tready beats, the third AR issues.
- Error: slave returns rresp=2'b10 on beat 5 → rd_err=1, all 16 beats still output. A new start clears rd_err.
- burst_num=0 → no arvalid, done pulses within 2 cycles.
- Reset asserted mid-DATA (beat 7) → all outputs 0 immediately. A subsequent start runs a clean single burst.
